// File: rtl/simplez_control.sv
// SIMPLEZ microsequencer: fetch/decode/execute FSM driving every datapath microorder.
// Outputs are combinational from state (plus opcode/z in E0); halts until reset.
module simplez_control #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [OPW-1:0] opcode,
  input  logic           z,
  output logic           lec,
  output logic           esc,
  output logic           era,
  output logic           incp,
  output logic           ecp,
  output logic           ccp,
  output logic           scp,
  output logic           eri,
  output logic           sri,
  output logic           eac,
  output logic           sac,
  output logic [1:0]     alu_op,
  output logic           fetch,
  output logic           stop
);

  typedef enum logic [2:0] {
    S_INIT, S_F0, S_F1, S_F2, S_E0, S_E1, S_E2, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ST  = OPW'(0);
  localparam logic [OPW-1:0] OP_LD  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_BR  = OPW'(3);
  localparam logic [OPW-1:0] OP_BZ  = OPW'(4);
  localparam logic [OPW-1:0] OP_CLR = OPW'(5);
  localparam logic [OPW-1:0] OP_DEC = OPW'(6);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lec     = 1'b0;
    esc     = 1'b0;
    era     = 1'b0;
    incp    = 1'b0;
    ecp     = 1'b0;
    ccp     = 1'b0;
    scp     = 1'b0;
    eri     = 1'b0;
    sri     = 1'b0;
    eac     = 1'b0;
    sac     = 1'b0;
    alu_op  = 2'b00;
    fetch   = 1'b0;
    stop    = 1'b0;
    case (state_q)
      S_INIT: begin
        ccp     = 1'b1;
        state_d = S_F0;
      end
      S_F0: begin
        scp     = 1'b1;
        era     = 1'b1;
        fetch   = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        lec     = 1'b1;
        incp    = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        eri     = 1'b1;
        state_d = S_E0;
      end
      S_E0: begin
        // Latch the opcode so E1/E2 are immune to later RI changes.
        op_d    = opcode;
        state_d = S_F0;
        case (opcode)
          OP_ST, OP_LD, OP_ADD: begin
            sri     = 1'b1;
            era     = 1'b1;
            state_d = S_E1;
          end
          OP_BR: begin
            sri = 1'b1;
            ecp = 1'b1;
          end
          OP_BZ: begin
            sri = z;
            ecp = z;
          end
          OP_CLR: begin
            eac    = 1'b1;
            alu_op = 2'b11;
          end
          OP_DEC: begin
            eac    = 1'b1;
            alu_op = 2'b10;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_E1: begin
        if (op_q == OP_ST) begin
          sac     = 1'b1;
          esc     = 1'b1;
          state_d = S_F0;
        end else begin
          lec     = 1'b1;
          state_d = S_E2;
        end
      end
      S_E2: begin
        eac     = 1'b1;
        alu_op  = (op_q == OP_LD) ? 2'b01 : 2'b00;
        state_d = S_F0;
      end
      S_HALT: stop = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_simplez_control.sv
// Bench for simplez_control: per-cycle vector table through a scoreboard queue,
// plus hand-written reset/halt sequences and a continuous invariant check.
module tb_simplez_control;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] opcode = 3'b111;
  logic       z = 1'b0;
  logic       lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, fetch, stop;
  logic [1:0] alu_op;
  logic [14:0] outs;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  simplez_control #(.OPW(3)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .z(z),
    .lec(lec), .esc(esc), .era(era), .incp(incp), .ecp(ecp), .ccp(ccp),
    .scp(scp), .eri(eri), .sri(sri), .eac(eac), .sac(sac),
    .alu_op(alu_op), .fetch(fetch), .stop(stop)
  );

  assign outs = {lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, fetch, stop};

  localparam logic [14:0] LEC = 15'h4000, ESC = 15'h2000, ERA = 15'h1000, INCP = 15'h0800;
  localparam logic [14:0] ECP = 15'h0400, CCP = 15'h0200, SCP = 15'h0100, ERI = 15'h0080;
  localparam logic [14:0] SRI = 15'h0040, EAC = 15'h0020, SAC = 15'h0010, ALU01 = 15'h0004;
  localparam logic [14:0] ALU10 = 15'h0008, ALU11 = 15'h000C, FETCH = 15'h0002, STOP = 15'h0001;
  localparam logic [14:0] FE0 = SCP | ERA | FETCH;
  localparam logic [14:0] FE1 = LEC | INCP;
  localparam logic [14:0] FE2 = ERI;

  typedef struct {
    logic [2:0]  op;
    logic        zz;
    logic [14:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];

  task automatic add(input logic [2:0] op, input logic zz, input logic [14:0] exp);
    vec_t v;
    v.op = op; v.zz = zz; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name);
    logic [14:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected entry queued, got %h", name, outs);
    end else begin
      e = exp_q.pop_front();
      if (outs !== e) begin
        fails++;
        $display("FAIL %s @%0t: got %h required %h", name, $time, outs, e);
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge.
  task automatic step(input logic [2:0] op, input logic zz, input logic [14:0] exp, input string name);
    @(posedge clk);
    #1;
    opcode = op;
    z      = zz;
    exp_q.push_back(exp);
    @(negedge clk);
    compare(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    exp_q.push_back(CCP);
    @(negedge clk);
    compare("reset_held");
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.push_back(CCP);
    @(negedge clk);
    compare("reset_released_init");
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(scp && sri) && !(sac && lec) && ($countones({ecp, incp, ccp}) <= 1) && (!esc || sac))
    else begin
      fails++;
      $display("FAIL invariant @%0t: outs=%h", $time, outs);
    end
  end

  initial begin
    // LD then ADD, with RI changing in E1/E2 to exercise the opcode latch
    add(3'd7, 0, FE0); add(3'd5, 0, FE1); add(3'd0, 0, FE2);
    add(3'd1, 0, SRI | ERA); add(3'd2, 0, LEC); add(3'd0, 0, EAC | ALU01);
    add(3'd6, 0, FE0); add(3'd6, 0, FE1); add(3'd6, 0, FE2);
    add(3'd2, 0, SRI | ERA); add(3'd0, 0, LEC); add(3'd1, 0, EAC);
    // ST: esc for exactly one cycle
    add(3'd3, 0, FE0); add(3'd3, 0, FE1); add(3'd3, 0, FE2);
    add(3'd0, 0, SRI | ERA); add(3'd1, 0, SAC | ESC);
    // BZ taken then not taken, z toggled in F1/F2
    add(3'd4, 0, FE0); add(3'd4, 0, FE1); add(3'd4, 0, FE2); add(3'd4, 1, SRI | ECP);
    add(3'd4, 1, FE0); add(3'd4, 1, FE1); add(3'd4, 1, FE2); add(3'd4, 0, 15'h0000);
    // CLR, DEC, BR
    add(3'd5, 0, FE0); add(3'd5, 0, FE1); add(3'd5, 0, FE2); add(3'd5, 0, EAC | ALU11);
    add(3'd6, 1, FE0); add(3'd6, 1, FE1); add(3'd6, 1, FE2); add(3'd6, 1, EAC | ALU10);
    add(3'd3, 0, FE0); add(3'd3, 0, FE1); add(3'd3, 0, FE2); add(3'd3, 0, SRI | ECP);
    // HALT at the end of the program
    add(3'd0, 0, FE0); add(3'd0, 0, FE1); add(3'd0, 0, FE2); add(3'd7, 0, 15'h0000);
    add(3'd0, 1, STOP); add(3'd1, 0, STOP); add(3'd4, 1, STOP);

    // Reset release with HALT opcode held: stop from cycle 5, held for 20+
    do_reset();
    step(3'd7, 0, FE0, "halt_f0");
    step(3'd7, 0, FE1, "halt_f1");
    step(3'd7, 0, FE2, "halt_f2");
    step(3'd7, 0, 15'h0000, "halt_e0");
    for (int i = 0; i < 22; i++) step(3'd7, i[0], STOP, "halt_hold");

    // Table-driven program
    do_reset();
    foreach (tbl[i]) step(tbl[i].op, tbl[i].zz, tbl[i].exp, $sformatf("vec%0d", i));

    // Reset during ST E1: esc must drop without waiting for a clock edge
    do_reset();
    step(3'd0, 0, FE0, "rst_st_f0");
    step(3'd0, 0, FE1, "rst_st_f1");
    step(3'd0, 0, FE2, "rst_st_f2");
    step(3'd0, 0, SRI | ERA, "rst_st_e0");
    step(3'd0, 0, SAC | ESC, "rst_st_e1");
    #2 rstn = 1'b0;
    #1;
    exp_q.push_back(CCP);
    compare("async_reset_esc_drop");
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.push_back(CCP);
    @(negedge clk);
    compare("async_reset_init");
    step(3'd2, 0, FE0, "restart_f0");
    step(3'd2, 0, FE1, "restart_f1");
    step(3'd2, 0, FE2, "restart_f2");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
